// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: debounced ps2c, 11-bit frame assembly, byte strobe.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, DATA} state_t;

    state_t                  state;
    logic                    ps2c_p0, ps2c_p1;
    logic                    ps2d_p0, ps2d_p1;
    logic [FILTER_LEN-1:0]   f_reg;
    logic                    f_val;
    logic                    all_lo, all_hi, fall;
    logic [3:0]              n_reg;
    logic [TO_W-1:0]         to_cnt;
    logic [8:0]              b_reg;

    // Stage p0/p1: two-flop synchronisers for both PS/2 lines
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= ps2c;
            ps2c_p1 <= ps2c_p0;
        end
    end

    always_ff @(posedge clk) begin
        ps2d_p0 <= ps2d;
        ps2d_p1 <= ps2d_p0;
    end

    // ps2c debounce: the filtered level only moves on a unanimous window
    assign all_lo = (f_reg == '0);
    assign all_hi = (f_reg == '1);
    assign fall   = f_val & all_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_reg <= '1;
            f_val <= 1'b1;
        end else begin
            f_reg <= {ps2c_p1, f_reg[FILTER_LEN-1:1]};
            if (all_lo)
                f_val <= 1'b0;
            else if (all_hi)
                f_val <= 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // b_reg holds {parity, data[7:0]} once nine bits have shifted in; the stop
    // bit is judged straight from the line on the final edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            n_reg        <= 4'd0;
            to_cnt       <= '0;
            dout         <= 8'h00;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall && !ps2d_p1 && rx_en) begin
                        state  <= DATA;
                        n_reg  <= 4'd10;
                        to_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        b_reg  <= {ps2d_p1, b_reg[8:1]};
                        n_reg  <= n_reg - 4'd1;
                        to_cnt <= '0;
                        if (n_reg == 4'd1) begin
                            state <= IDLE;
                            if (!ps2d_p1)
                                frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                            else if (!(^b_reg))
                                parity_err_q <= 1'b1;
`endif
                            else begin
                                dout         <= b_reg[7:0];
                                rx_done_tick <= 1'b1;
                            end
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
